// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side sync decoder recovering beam position and lock status
//
// Recovers the 1-based beam position (o_X 1..P_H_MAX, o_Y 1..P_V_MAX) from
// active-low HSync/VSync arriving on the pixel clock. The convention matches the
// timing generator: the cycle carrying the HSync falling edge shows
// o_X == P_H_PULSE_HEAD, and the cycle carrying the VSync falling edge is
// followed by o_Y == P_V_PULSE_HEAD.
//
// Ports:
//   i_Clk         pixel clock, all logic on posedge
//   i_Reset       synchronous active-high reset
//   i_HSync       horizontal sync, active low
//   i_VSync       vertical sync, active low
//   o_X, o_Y      recovered column / row (10 bits, 1-based)
//   o_HLocked     horizontal lock state machine is LOCKED
//   o_VLocked     vertical lock state machine is LOCKED
//   o_Visible     both locked and inside the visible rectangle
//   o_FrameStart  one-cycle pulse at (1,1) while both locked
//   o_ErrCount    saturating count of cycles with a lock-loss event
//
// Optional feature macro: VGA_DEC_STATS_EN builds the error counter; without it
// o_ErrCount is tied to zero.

module vga_sync_decoder #(
    parameter int P_H_VISIBLE    = 640,
    parameter int P_H_PULSE_HEAD = 657,
    parameter int P_H_MAX        = 800,
    parameter int P_V_VISIBLE    = 480,
    parameter int P_V_PULSE_HEAD = 491,
    parameter int P_V_MAX        = 525,
    parameter int P_LOCK_LINES   = 4,
    parameter int P_LOCK_FRAMES  = 2
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic [9:0] o_X,
    output logic [9:0] o_Y,
    output logic       o_HLocked,
    output logic       o_VLocked,
    output logic       o_Visible,
    output logic       o_FrameStart,
    output logic [7:0] o_ErrCount
);

    localparam logic [9:0] H_VIS  = 10'(P_H_VISIBLE);
    localparam logic [9:0] H_HEAD = 10'(P_H_PULSE_HEAD);
    localparam logic [9:0] H_MAX  = 10'(P_H_MAX);
    localparam logic [9:0] V_VIS  = 10'(P_V_VISIBLE);
    localparam logic [9:0] V_HEAD = 10'(P_V_PULSE_HEAD);
    localparam logic [9:0] V_MAX  = 10'(P_V_MAX);
    localparam logic [3:0] H_NEED = 4'(P_LOCK_LINES);
    localparam logic [3:0] V_NEED = 4'(P_LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    logic [9:0]  x, y, x_next, y_next;
    logic        h_prev, v_prev;
    logic        row_seen, row_seen_next;
    lock_state_t h_state, h_next, v_state, v_next;
    logic [3:0]  h_good, h_good_next, v_good, v_good_next;

    logic h_fall, v_fall;
    logic x_at_head, y_at_head, x_wrap;
    logic v_expected, v_missing;

    function automatic logic [3:0] inc_sat(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Falling edges are seen in the same cycle the input goes low.
    assign h_fall    = ~i_HSync & h_prev;
    assign v_fall    = ~i_VSync & v_prev;
    assign x_at_head = (x == H_HEAD);
    assign y_at_head = (y == V_HEAD);
    // An HSync edge on the last column reloads x instead of wrapping it,
    // so that cycle does not count as a row change.
    assign x_wrap    = (x == H_MAX) & ~h_fall;

    assign v_expected = v_fall & y_at_head;
    // The sync row is ending without any VSync edge inside it.
    assign v_missing  = x_wrap & y_at_head & ~(row_seen | v_fall);

    // Position counters
    always_comb begin
        x_next        = x;
        y_next        = y;
        row_seen_next = row_seen;

        if (h_fall)
            x_next = H_HEAD + 10'd1;
        else if (x == H_MAX)
            x_next = 10'd1;
        else
            x_next = x + 10'd1;

        if (v_fall)
            y_next = V_HEAD;
        else if (x_wrap)
            y_next = (y == V_MAX) ? 10'd1 : y + 10'd1;

        if (v_fall)
            row_seen_next = 1'b1;
        else if (x_wrap)
            row_seen_next = 1'b0;
    end

    // Horizontal lock next-state
    always_comb begin
        h_next      = h_state;
        h_good_next = h_good;
        case (h_state)
            ST_UNLOCKED: begin
                if (h_fall) begin
                    h_next      = ST_ACQUIRE;
                    h_good_next = 4'd1;
                end
            end
            ST_ACQUIRE: begin
                if (h_fall && x_at_head) begin
                    h_good_next = inc_sat(h_good);
                    if (h_good_next >= H_NEED)
                        h_next = ST_LOCKED;
                end else if (h_fall) begin
                    h_good_next = 4'd1;
                end else if (x_at_head) begin
                    h_next = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (h_fall && !x_at_head) begin
                    h_next      = ST_ACQUIRE;
                    h_good_next = 4'd1;
                end else if (!h_fall && x_at_head) begin
                    h_next = ST_UNLOCKED;
                end
            end
            default: h_next = ST_UNLOCKED;
        endcase
    end

    // Vertical lock next-state. It is dropped in the same cycle H leaves LOCKED
    // so that a single sync loss is recorded as a single error cycle.
    always_comb begin
        v_next      = v_state;
        v_good_next = v_good;
        if (h_next != ST_LOCKED) begin
            v_next      = ST_UNLOCKED;
            v_good_next = 4'd0;
        end else if (h_state == ST_LOCKED) begin
            case (v_state)
                ST_UNLOCKED: begin
                    if (v_fall) begin
                        v_next      = ST_ACQUIRE;
                        v_good_next = 4'd1;
                    end
                end
                ST_ACQUIRE: begin
                    if (v_expected) begin
                        v_good_next = inc_sat(v_good);
                        if (v_good_next >= V_NEED)
                            v_next = ST_LOCKED;
                    end else if (v_fall) begin
                        v_good_next = 4'd1;
                    end else if (v_missing) begin
                        v_next = ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (v_fall && !v_expected) begin
                        v_next      = ST_ACQUIRE;
                        v_good_next = 4'd1;
                    end else if (v_missing) begin
                        v_next = ST_UNLOCKED;
                    end
                end
                default: v_next = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            x        <= 10'd1;
            y        <= 10'd1;
            h_prev   <= 1'b1;
            v_prev   <= 1'b1;
            row_seen <= 1'b0;
            h_state  <= ST_UNLOCKED;
            v_state  <= ST_UNLOCKED;
            h_good   <= 4'd0;
            v_good   <= 4'd0;
        end else begin
            x        <= x_next;
            y        <= y_next;
            h_prev   <= i_HSync;
            v_prev   <= i_VSync;
            row_seen <= row_seen_next;
            h_state  <= h_next;
            v_state  <= v_next;
            h_good   <= h_good_next;
            v_good   <= v_good_next;
        end
    end

    assign o_X          = x;
    assign o_Y          = y;
    assign o_HLocked    = (h_state == ST_LOCKED);
    assign o_VLocked    = (v_state == ST_LOCKED);
    assign o_Visible    = o_HLocked & o_VLocked & (x <= H_VIS) & (y <= V_VIS);
    assign o_FrameStart = o_HLocked & o_VLocked & (x == 10'd1) & (y == 10'd1);

`ifdef VGA_DEC_STATS_EN
    logic       err_event;
    logic [7:0] err_count;

    assign err_event = ((h_state != ST_UNLOCKED) && (h_next == ST_UNLOCKED)) ||
                       ((h_state == ST_LOCKED)   && (h_next == ST_ACQUIRE))  ||
                       ((v_state != ST_UNLOCKED) && (v_next == ST_UNLOCKED)) ||
                       ((v_state == ST_LOCKED)   && (v_next == ST_ACQUIRE));

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            err_count <= 8'd0;
        else if (err_event && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
    end

    assign o_ErrCount = err_count;
`else
    assign o_ErrCount = 8'd0;
`endif

endmodule
